// File: rtl/seq_div.sv
// seq_div: iterative restoring divider, 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Define DIV_EARLY_OVF_EN to finish overflow/divide-by-zero requests one cycle after accept.
`default_nettype none

module seq_div #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           ovf
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_CNT_FULL = CW'(N);
`ifdef DIV_EARLY_OVF_EN
  localparam logic [CW-1:0] C_CNT_OVF = CW'(1);
`else
  localparam logic [CW-1:0] C_CNT_OVF = CW'(N);
`endif

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_p, w_p_nxt;
  logic [N-1:0]  r_lo, w_lo_nxt;
  logic [N-1:0]  r_dvs, w_dvs_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_ovf_pend, w_ovf_pend_nxt;
  logic [N-1:0]  r_quo, w_quo_nxt;
  logic [N-1:0]  r_rem, w_rem_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic          r_done, w_done_nxt;

  logic [N:0]    w_shift;
  logic [N:0]    w_diff;
  logic          w_ge;
  logic [N-1:0]  w_p_iter;
  logic          w_ovf_acc;

  // r_lo holds the not-yet-consumed dividend bits; quotient bits shift in at the LSB.
  // The partial remainder is stored in N bits because it is always below the divisor.
  always_comb begin
    w_shift   = {r_p, r_lo[N-1]};
    w_diff    = w_shift - {1'b0, r_dvs};
    w_ge      = w_shift[N] | ~w_diff[N];
    w_p_iter  = w_ge ? w_diff[N-1:0] : w_shift[N-1:0];
    w_ovf_acc = (divisor == '0) || (dividend[2*N-1:N] >= divisor);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_p_nxt        = r_p;
    w_lo_nxt       = r_lo;
    w_dvs_nxt      = r_dvs;
    w_cnt_nxt      = r_cnt;
    w_ovf_pend_nxt = r_ovf_pend;
    w_quo_nxt      = r_quo;
    w_rem_nxt      = r_rem;
    w_ovf_nxt      = r_ovf;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_dvs_nxt      = divisor;
          w_p_nxt        = dividend[2*N-1:N];
          w_lo_nxt       = dividend[N-1:0];
          w_ovf_pend_nxt = w_ovf_acc;
          w_cnt_nxt      = w_ovf_acc ? C_CNT_OVF : C_CNT_FULL;
          w_state_nxt    = S_RUN;
        end
      end
      S_RUN: begin
        w_p_nxt   = w_p_iter;
        w_lo_nxt  = {r_lo[N-2:0], w_ge};
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          if (r_ovf_pend) begin
            w_quo_nxt = '1;
            w_rem_nxt = '0;
            w_ovf_nxt = 1'b1;
          end else begin
            w_quo_nxt = {r_lo[N-2:0], w_ge};
            w_rem_nxt = w_p_iter;
            w_ovf_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_p        <= '0;
      r_lo       <= '0;
      r_dvs      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_p        <= w_p_nxt;
      r_lo       <= w_lo_nxt;
      r_dvs      <= w_dvs_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf_pend <= w_ovf_pend_nxt;
      r_quo      <= w_quo_nxt;
      r_rem      <= w_rem_nxt;
      r_ovf      <= w_ovf_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized scoreboard bench for seq_div against an arithmetic reference model.
`default_nettype none

module tb_seq_div;

  localparam int N = 4;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           ovf;

  seq_div #(.N(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .ovf      (ovf)
  );

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         ovf;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic [N-1:0] hold_q = '0;
  logic [N-1:0] hold_r = '0;
  logic         hold_o = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division; overflow when the quotient cannot fit in N bits.
  function automatic exp_t model(input logic [2*N-1:0] a, input logic [N-1:0] b, input int acc);
    exp_t   e;
    longint ua = longint'(a);
    longint ub = longint'(b);
    e.acc = acc;
    e.ovf = (ub == 0) || ((ua / ub) >= (longint'(1) << N));
    if (e.ovf) begin
      e.q = '1;
      e.r = '0;
    end else begin
      e.q = N'(ua / ub);
      e.r = N'(ua % ub);
    end
`ifdef DIV_EARLY_OVF_EN
    e.lat = e.ovf ? 1 : N;
`else
    e.lat = N;
`endif
    return e;
  endfunction

  task automatic issue(input logic [2*N-1:0] a, input logic [N-1:0] b);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: busy stuck high, expected low within 200 cycles");
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start    = 1'b0;
    dividend = 2*N'($urandom);
    divisor  = N'($urandom);
    check("busy_after_accept", longint'(busy), 1);
  endtask

  // Monitor: pops one expectation per done pulse; between completions outputs must hold.
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_q = '0;
      hold_r = '0;
      hold_o = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", longint'(quotient), longint'(e.q));
        check("remainder", longint'(remainder), longint'(e.r));
        check("ovf", longint'(ovf), longint'(e.ovf));
        check("latency", longint'(cyc - e.acc), longint'(e.lat));
        check("busy_at_done", longint'(busy), 0);
        hold_q = e.q;
        hold_r = e.r;
        hold_o = e.ovf;
      end
    end else begin
      check("hold_quotient", longint'(quotient), longint'(hold_q));
      check("hold_remainder", longint'(remainder), longint'(hold_r));
      check("hold_ovf", longint'(ovf), longint'(hold_o));
    end
  end

  initial begin
    int guard;
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_quotient", longint'(quotient), 0);
    check("rst_remainder", longint'(remainder), 0);
    check("rst_ovf", longint'(ovf), 0);
    reset_n = 1'b1;

    issue(8'd100, 4'd7);
    issue(8'd200, 4'd15);
    issue(8'd45, 4'd3);
    issue(8'h50, 4'd5);
    issue(8'h37, 4'd0);
    issue(8'hFF, 4'd0);
    issue(8'hEF, 4'd15);

    // A start pulse mid-run must be ignored.
    issue(8'd100, 4'd7);
    @(negedge clk);
    dividend = 8'd45;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;

    // Reset mid-run abandons the division and clears the outputs at once.
    issue(8'd200, 4'd15);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_done", longint'(done), 0);
    check("midrst_quotient", longint'(quotient), 0);
    check("midrst_remainder", longint'(remainder), 0);
    check("midrst_ovf", longint'(ovf), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    issue(8'd100, 4'd7);

    for (int i = 0; i < 60; i++) begin
      logic [2*N-1:0] a;
      logic [N-1:0]   b;
      a = 2*N'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      issue(a, b);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
